// File: rtl/writeback_queue.sv
// writeback_queue: small FIFO between execute and the register-file write port.
// Each edge can accept one result and retire the oldest one to the register file.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   res_valid/res_ready         result handshake (res_ready = !full)
//   res_addr[2:0], res_data[7:0] offered result (addr 0 is accepted then dropped)
//   flush                       synchronous discard of queue and pending write
//   hold                        stall draining toward the register file
//   rf_we, rf_addr, rf_data     registered register-file write port
//   chk_a_addr, chk_b_addr      operand addresses to check
//   a_pending, b_pending        operand has a write queued or on the port
//   count, empty, full          queue occupancy
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       res_valid,
    output logic       res_ready,
    input  logic [2:0] res_addr,
    input  logic [7:0] res_data,
    input  logic       flush,
    input  logic       hold,
    output logic       rf_we,
    output logic [2:0] rf_addr,
    output logic [7:0] rf_data,
    input  logic [2:0] chk_a_addr,
    input  logic [2:0] chk_b_addr,
    output logic       a_pending,
    output logic       b_pending,
    output logic [3:0] count,
    output logic       empty,
    output logic       full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][2:0] r_mem_addr;
    logic [DEPTH-1:0][7:0] r_mem_data;
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [3:0]            r_count;
    logic                  r_rf_we;
    logic [2:0]            r_rf_addr;
    logic [7:0]            r_rf_data;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_xfer;
    logic                  w_push;
    logic                  w_pop;
    logic [DEPTH-1:0]      w_match_a;
    logic [DEPTH-1:0]      w_match_b;

    assign w_full  = (r_count == 4'(DEPTH));
    assign w_empty = (r_count == 4'd0);
    assign w_xfer  = res_valid && !w_full;
    // r0 writes complete the handshake but never occupy an entry.
    assign w_push  = w_xfer && !flush && (res_addr != 3'd0);
    assign w_pop   = !hold && !flush && !w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_rf_we   <= 1'b0;
            r_rf_addr <= '0;
            r_rf_data <= '0;
        end else if (flush) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_rf_we   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + 4'd1;
            else if (!w_push && w_pop) r_count <= r_count - 4'd1;
            r_rf_we <= w_pop;
            if (w_pop) begin
                r_rf_addr <= r_mem_addr[r_rptr];
                r_rf_data <= r_mem_data[r_rptr];
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wptr] <= res_addr;
            r_mem_data[r_wptr] <= res_data;
        end
    end

    // An entry is live when its distance from the head is below count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic [PW-1:0] w_off;
        logic          w_live;
        assign w_off        = PW'(g) - r_rptr;
        assign w_live       = ({{(4-PW){1'b0}}, w_off} < r_count);
        assign w_match_a[g] = w_live && (r_mem_addr[g] == chk_a_addr);
        assign w_match_b[g] = w_live && (r_mem_addr[g] == chk_b_addr);
    end

    assign a_pending = (chk_a_addr != 3'd0) &&
                       ((|w_match_a) || (r_rf_we && (r_rf_addr == chk_a_addr)));
    assign b_pending = (chk_b_addr != 3'd0) &&
                       ((|w_match_b) || (r_rf_we && (r_rf_addr == chk_b_addr)));

    assign res_ready = !w_full;
    assign rf_we     = r_rf_we;
    assign rf_addr   = r_rf_addr;
    assign rf_data   = r_rf_data;
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
endmodule
